serial_operand_tx: RTL

- Transmit side of the bit-serial adder link: accepts two W-bit operands on a valid/ready handshake and shifts them out LSB-first on serial lines a and b, one bit per clk.
- After the W data bits it emits PAD zero bits so the downstream serial adder's two-cycle pipeline drains and its final carry is captured.
- Frame framing strobes (first, last, frame) let the receiver align without a free-running counter.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/piso_shreg.sv | 36 +++
 rtl/serial_operand_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the bit-serial adder link transmitter.
//   tx_state_t : transmitter FSM states (IDLE, SHIFT, PAD)
//   DEF_W      : default operand width
//   DEF_PAD    : default number of trailing zero bits
//   frame_len  : total bit cycles in one frame (data + pad)
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAD
  } tx_state_t;

  localparam int unsigned DEF_W   = 4;
  localparam int unsigned DEF_PAD = 2;

  function automatic int unsigned frame_len(input int unsigned w, input int unsigned pad);
    return w + pad;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: W-bit parallel-in / serial-out register, LSB first.
// Right shift with zero fill, so once the data bits are out the serial
// output reads 0.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (clears the register)
//   load  : parallel load of din (has priority over shift)
//   shift : shift right one place, zero into the MSB
//   din   : parallel data
//   sout  : current LSB (registered)
module piso_shreg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q >> 1;
    end
  end

  always_comb sout = q[0];

endmodule

// File: rtl/serial_operand_tx.sv
// serial_operand_tx: transmit side of the bit-serial adder link.
// Accepts an operand pair on a valid/ready handshake and sends both operands
// LSB first on a/b, one bit per clock, followed by PAD zero bits so the
// receiving serial adder can drain and capture its final carry.
// Optional feature macro: SERIAL_TX_SUB_EN (adds sub input / cin output;
// with sub=1 the B bits go out inverted and cin=1 on bit 0, giving A-B).
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   in_valid : operand pair offered
//   in_ready : pair can be accepted this cycle (idle, or last frame cycle)
//   in_a     : operand A, sampled on handshake
//   in_b     : operand B, sampled on handshake
//   sub      : (SERIAL_TX_SUB_EN) subtract request, sampled on handshake
//   cin      : (SERIAL_TX_SUB_EN) carry-in strobe on bit 0 of a subtract
//   a, b     : serial operand bits, LSB first, 0 during pad
//   frame    : high on every bit cycle of a frame
//   first    : high on bit 0 only
//   last     : high on the final cycle of the frame
//   busy     : frame in progress (same as frame)
module serial_operand_tx #(
  parameter int unsigned W   = serial_pkg::DEF_W,
  parameter int unsigned PAD = serial_pkg::DEF_PAD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
`ifdef SERIAL_TX_SUB_EN
  input  logic         sub,
  output logic         cin,
`endif
  output logic         a,
  output logic         b,
  output logic         frame,
  output logic         first,
  output logic         last,
  output logic         busy
);

  import serial_pkg::*;

  localparam int unsigned FLEN = frame_len(W, PAD);
  localparam int unsigned CW   = (FLEN > 1) ? $clog2(FLEN) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FLEN - 1);

  tx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hs;
  logic [W-1:0]  b_load;

  always_comb in_ready = rst & ((state == IDLE) | last);
  always_comb hs = in_valid & in_ready;
  always_comb busy = frame;

`ifdef SERIAL_TX_SUB_EN
  always_comb b_load = sub ? ~in_b : in_b;
`else
  always_comb b_load = in_b;
`endif

  // cnt is the index of the bit cycle currently on the outputs; 'last' is
  // the registered end-of-frame flag, so no PAD state is entered when PAD=0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (hs) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      default: begin
        if (last) begin
          state_n = hs ? SHIFT : IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
          if (state == SHIFT && cnt == LAST_BIT) begin
            state_n = serial_pkg::PAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      frame <= 1'b0;
      first <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      frame <= (state_n != IDLE);
      first <= hs;
      last  <= (state_n != IDLE) && (cnt_n == LAST_CNT);
    end
  end

`ifdef SERIAL_TX_SUB_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cin <= 1'b0;
    end else begin
      cin <= hs & sub;
    end
  end
`endif

  // Both registers shift on every frame cycle; the zero fill provides the pad.
  piso_shreg #(.W(W)) u_sh_a (
    .clk   (clk),
    .rst   (rst),
    .load  (hs),
    .shift (frame),
    .din   (in_a),
    .sout  (a)
  );

  piso_shreg #(.W(W)) u_sh_b (
    .clk   (clk),
    .rst   (rst),
    .load  (hs),
    .shift (frame),
    .din   (b_load),
    .sout  (b)
  );

endmodule
